// File: rtl/uart_receive.sv
// -----------------------------------------------------------------------------
// uart_receive
// -----------------------------------------------------------------------------
// Purpose:
//   8N1, LSB-first UART receiver that is the counterpart of uart_transmit on the
//   FTDI2232 link. The raw serial pin is synchronised, each bit cell is sampled
//   three times around its centre and majority-voted, and each accepted byte is
//   presented with a one-cycle valid pulse. A start bit that does not survive
//   its centre vote is treated as a glitch and dropped silently. A stop bit
//   that votes 0 raises a one-cycle framing-error pulse, and the receiver then
//   waits for the line to return high before it looks for a new start bit.
//
// Parameters:
//   CLK_HZ     system clock frequency in Hz
//   BAUD_RATE  serial line rate; must match uart_transmit
//
// Ports:
//   clk_in             in   1  system clock
//   rst_in             in   1  synchronous, active-high reset
//   rx_wire_in         in   1  asynchronous serial line, idle high
//   data_byte_out      out  8  last correctly received byte, held until the next
//   data_valid_out     out  1  one-cycle pulse when data_byte_out is updated
//   framing_error_out  out  1  one-cycle pulse when a stop bit votes 0
//   busy_out           out  1  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_receive #(
   parameter int CLK_HZ    = 100_000_000,
   parameter int BAUD_RATE = 460800
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       rx_wire_in,
   output logic [7:0] data_byte_out,
   output logic       data_valid_out,
   output logic       framing_error_out,
   output logic       busy_out
);

   // Clock cycles per bit cell, and the centre count within a cell.
   localparam int PERIOD = CLK_HZ / BAUD_RATE;
   localparam int MID    = PERIOD / 2;
   localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   localparam logic [CW-1:0] CNT_LAST   = CW'(PERIOD - 1);
   localparam logic [CW-1:0] CNT_TAP0   = CW'(MID - 1);
   localparam logic [CW-1:0] CNT_TAP1   = CW'(MID);
   localparam logic [CW-1:0] CNT_VOTE   = CW'(MID + 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [2:0]    LAST_BIT   = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   // Two-flop synchroniser; both stages rest at the idle line level.
   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;   // position inside the current bit cell
   logic [2:0]    bit_q, bit_d;       // data bit index 0..7
   logic [7:0]    shift_q, shift_d;   // data bits, shifted in from the MSB end
   logic          tap0_q, tap0_d;     // sample at MID-1
   logic          tap1_q, tap1_d;     // sample at MID
   logic [7:0]    byte_q, byte_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;

   logic          count_wrap;
   logic [CW-1:0] count_next;
   logic          vote_now;
   logic          vote;

   // The third vote sample is the synchronised line at count MID+1 itself,
   // so the majority is available on the same cycle it is needed.
   assign vote = (tap0_q & tap1_q) | (tap0_q & sync2_q) | (tap1_q & sync2_q);

   assign count_wrap = (count_q == CNT_LAST);
   assign count_next = count_wrap ? '0 : count_q + CNT_ONE;
   assign vote_now   = (count_q == CNT_VOTE);

   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      sync1_d  = rx_wire_in;
      sync2_d  = sync1_q;
      state_d  = state_q;
      count_d  = count_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tap0_d   = tap0_q;
      tap1_d   = tap1_q;
      byte_d   = byte_q;
      valid_d  = 1'b0;
      ferr_d   = 1'b0;

      // Capture the two early vote samples in every active cell.
      if (state_q != S_IDLE) begin
         if (count_q == CNT_TAP0) tap0_d = sync2_q;
         if (count_q == CNT_TAP1) tap1_d = sync2_q;
      end

      case (state_q)
         S_IDLE: begin
            count_d = '0;
            // The detection cycle is count 0 of the start cell, so the
            // counter resumes at 1 on the following cycle.
            if (!sync2_q) begin
               state_d = S_START;
               count_d = CNT_ONE;
            end
         end

         S_START: begin
            count_d = count_next;
            if (vote_now && vote) begin
               // The low level did not hold to the cell centre: glitch.
               state_d = S_IDLE;
               count_d = '0;
            end else if (count_wrap) begin
               state_d = S_DATA;
               bit_d   = '0;
            end
         end

         S_DATA: begin
            count_d = count_next;
            if (vote_now) shift_d = {vote, shift_q[7:1]};
            if (count_wrap) begin
               if (bit_q == LAST_BIT) state_d = S_STOP;
               else                   bit_d   = bit_q + 3'd1;
            end
         end

         S_STOP: begin
            count_d = count_next;
            // Leave at the stop-bit centre so that a start bit immediately
            // following the stop bit is still caught from IDLE.
            if (vote_now) begin
               count_d = '0;
               if (vote) begin
                  byte_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_WAIT_IDLE;
               end
            end
         end

         S_WAIT_IDLE: begin
            // A held-low line (break) must not be mistaken for a new start.
            count_d = '0;
            if (sync2_q) state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            count_d = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= S_IDLE;
         count_q <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tap0_q  <= 1'b1;
         tap1_q  <= 1'b1;
         byte_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         state_q <= state_d;
         count_q <= count_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tap0_q  <= tap0_d;
         tap1_q  <= tap1_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign data_byte_out     = byte_q;
   assign data_valid_out    = valid_q;
   assign framing_error_out = ferr_q;
   assign busy_out          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receive.sv
// -----------------------------------------------------------------------------
// tb_uart_receive
// -----------------------------------------------------------------------------
// Directed bench for uart_receive at the default 100 MHz / 460800 baud.
// Frames are driven one line level per clock on the falling edge. Each
// expected byte, or framing error, is queued with the cycle in which it must
// appear. A monitor checks every pulse against the head of its queue.
// -----------------------------------------------------------------------------
module tb_uart_receive;

   localparam int PERIOD = 217;    // 100_000_000 / 460800
   localparam int MID    = 108;
   localparam int LAT    = 2065;   // line fall to valid, in clock cycles

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic       rx_wire_in;
   logic [7:0] data_byte_out;
   logic       data_valid_out;
   logic       framing_error_out;
   logic       busy_out;

   uart_receive dut (
      .clk_in            (clk_in),
      .rst_in            (rst_in),
      .rx_wire_in        (rx_wire_in),
      .data_byte_out     (data_byte_out),
      .data_valid_out    (data_valid_out),
      .framing_error_out (framing_error_out),
      .busy_out          (busy_out)
   );

   always #5 clk_in = ~clk_in;

   // Rising-edge count; read on falling edges only.
   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];   // expected valid pulses
   int   err_q[$];   // expected framing-error pulse cycles

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one 10-cell frame starting at the current falling edge. A
   // glitch_at of -1 means no glitch; a rst_at of -1 means no reset.
   // The line is left at the stop-bit level.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             input int glitch_at, input int rst_at);
      int         n;
      logic [9:0] bits;
      exp_t       e;
      n    = cyc;
      bits = {stop_bit, b, 1'b0};
      if (rst_at < 0) begin
         if (stop_bit) begin
            e.data = b;
            e.cyc  = n + LAT;
            exp_q.push_back(e);
         end else begin
            err_q.push_back(n + LAT);
         end
      end
      for (int c = 0; c < 10 * PERIOD; c++) begin
         if (rst_at >= 0 && c == rst_at + 1) begin
            check("rst_byte",  {24'd0, data_byte_out}, 32'h0);
            check("rst_valid", {31'd0, data_valid_out}, 32'h0);
            check("rst_ferr",  {31'd0, framing_error_out}, 32'h0);
            check("rst_busy",  {31'd0, busy_out}, 32'h0);
         end
         rst_in     = (c == rst_at);
         rx_wire_in = bits[c / PERIOD] ^ (c == glitch_at);
         @(negedge clk_in);
      end
      rst_in = 1'b0;
   endtask

   // Monitor: every pulse is matched against the scoreboard.
   always @(negedge clk_in) begin
      exp_t e;
      int   ec;
      if (data_valid_out || framing_error_out)
         check("exclusive", {31'd0, data_valid_out & framing_error_out}, 32'h0);
      if (data_valid_out) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", {31'd0, data_valid_out}, 32'h0);
         end else begin
            e = exp_q.pop_front();
            check("byte", {24'd0, data_byte_out}, {24'd0, e.data});
            check("valid_cycle", cyc, e.cyc);
         end
      end
      if (framing_error_out) begin
         if (err_q.size() == 0) begin
            check("unexpected_ferr", {31'd0, framing_error_out}, 32'h0);
         end else begin
            ec = err_q.pop_front();
            check("ferr_cycle", cyc, ec);
         end
      end
   end

   // Watchdog well beyond the directed sequence length.
   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete within 60000 cycles");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;

      // Reset state.
      rst_in     = 1'b1;
      rx_wire_in = 1'b1;
      repeat (3) @(negedge clk_in);
      check("reset_byte",  {24'd0, data_byte_out}, 32'h0);
      check("reset_valid", {31'd0, data_valid_out}, 32'h0);
      check("reset_ferr",  {31'd0, framing_error_out}, 32'h0);
      check("reset_busy",  {31'd0, busy_out}, 32'h0);
      rst_in = 1'b0;
      repeat (10) @(negedge clk_in);
      check("idle_busy", {31'd0, busy_out}, 32'h0);

      // 1: single byte with exact latency.
      send_frame(8'hA5, 1'b1, -1, -1);
      repeat (20) @(negedge clk_in);

      // 2: back-to-back frames, no idle gap.
      send_frame(8'h00, 1'b1, -1, -1);
      send_frame(8'hFF, 1'b1, -1, -1);
      send_frame(8'h80, 1'b1, -1, -1);
      repeat (20) @(negedge clk_in);

      // 3: 50-cycle false start.
      n          = cyc;
      rx_wire_in = 1'b0;
      repeat (2) @(negedge clk_in);
      check("glitch_busy_pre", {31'd0, busy_out}, 32'h0);
      @(negedge clk_in);
      check("glitch_busy_det", {31'd0, busy_out}, 32'h1);
      repeat (47) @(negedge clk_in);
      rx_wire_in = 1'b1;
      while (cyc < n + MID + 3) @(negedge clk_in);
      check("glitch_busy_end", {31'd0, busy_out}, 32'h1);
      @(negedge clk_in);
      check("glitch_busy_idle", {31'd0, busy_out}, 32'h0);
      repeat (300) @(negedge clk_in);
      check("glitch_byte_held", {24'd0, data_byte_out}, 32'h80);
      send_frame(8'h3C, 1'b1, -1, -1);
      repeat (20) @(negedge clk_in);

      // 4: framing error, held-low line, then recovery.
      send_frame(8'h5A, 1'b0, -1, -1);
      repeat (5000) @(negedge clk_in);
      check("break_busy", {31'd0, busy_out}, 32'h1);
      check("ferr_byte_held", {24'd0, data_byte_out}, 32'h3C);
      rx_wire_in = 1'b1;
      repeat (4) @(negedge clk_in);
      check("break_release_busy", {31'd0, busy_out}, 32'h0);
      repeat (20) @(negedge clk_in);
      send_frame(8'h11, 1'b1, -1, -1);
      repeat (20) @(negedge clk_in);

      // 5: one-cycle glitch at the centre tap of data bit 4.
      send_frame(8'hF0, 1'b1, 5 * PERIOD + MID, -1);
      repeat (20) @(negedge clk_in);

      // 6: reset pulse in the middle of data bit 3, then a clean frame.
      send_frame(8'hF8, 1'b1, -1, 4 * PERIOD + MID);
      repeat (20) @(negedge clk_in);
      send_frame(8'h42, 1'b1, -1, -1);
      repeat (20) @(negedge clk_in);

      check("pending_valid", exp_q.size(), 32'h0);
      check("pending_ferr",  err_q.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
